// File: rtl/uart_module_nios2_gen2_cpu_debug_mem_ctrl_pkg.sv
// Shared constants for the debug memory controller: FSM state codes, jdo
// field positions, command kinds and status register layout.
package uart_module_nios2_gen2_cpu_debug_mem_ctrl_pkg;

   // FSM state codes
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_JRD   = 3'd1;
   localparam logic [2:0] ST_JCAP  = 3'd2;
   localparam logic [2:0] ST_JWR   = 3'd3;
   localparam logic [2:0] ST_AVRD  = 3'd4;
   localparam logic [2:0] ST_AVACK = 3'd5;

   // jdo field positions
   localparam int READ_REQ   = 17;
   localparam int CLR_STATUS = 25;
   localparam int DATA_LSB   = 3;
   localparam int ADDR_LSB   = 3;

   // status register bit indices
   localparam int SB_READY   = 0;
   localparam int SB_ERROR   = 1;
   localparam int SB_OVERRUN = 2;

   // JTAG command kinds (which strobe produced the command)
   localparam logic [1:0] CMD_A = 2'd0;   // take_action_ocimem_a
   localparam logic [1:0] CMD_B = 2'd1;   // take_action_ocimem_b
   localparam logic [1:0] CMD_N = 2'd2;   // take_no_action_ocimem_a

   localparam int BYTES_PER_WORD = 4;

   // Avalon view of the monitor status register
   function automatic logic [31:0] pack_status(input logic rdy, input logic err,
                                               input logic ovr);
      return {29'b0, ovr, err, rdy};
   endfunction

endpackage

// File: rtl/uart_module_nios2_gen2_cpu_debug_mem_ctrl_if.sv
// Bundle of debug-slave strobes, Avalon debug_mem_slave bus and monitor
// outputs. master = debug slave / CPU side, slave = memory controller.
interface uart_module_nios2_gen2_cpu_debug_mem_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int JDO_W  = 38
) ();
   logic [JDO_W-1:0]  jdo;
   logic              take_action_ocimem_a;
   logic              take_action_ocimem_b;
   logic              take_no_action_ocimem_a;
   logic [ADDR_W:0]   address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [3:0]        byteenable;
   logic              debugaccess;
   logic [31:0]       readdata;
   logic              waitrequest;
   logic [31:0]       MonDReg;
   logic              monitor_ready;
   logic              monitor_error;

   modport master (
      output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
      output address, read, write, writedata, byteenable, debugaccess,
      input  readdata, waitrequest, MonDReg, monitor_ready, monitor_error
   );

   modport slave (
      input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
      input  address, read, write, writedata, byteenable, debugaccess,
      output readdata, waitrequest, MonDReg, monitor_ready, monitor_error
   );
endinterface

// File: rtl/uart_module_nios2_gen2_cpu_debug_ram.sv
// Debug monitor RAM: single-port synchronous, byte-enabled writes,
// 1-cycle read latency, read-during-write returns the old word.
module uart_module_nios2_gen2_cpu_debug_ram
   import uart_module_nios2_gen2_cpu_debug_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [2**ADDR_W];
   logic [31:0] rdata_q;

   // registered read of the old word, byte-lane writes on the same edge
   always_ff @(posedge clk) begin
      rdata_q <= mem_q[addr_i];
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
         if (we_i && be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_module_nios2_gen2_cpu_debug_mem_ctrl.sv
// Sysclk-side debug memory controller. Executes JTAG monitor commands from
// the debug slave, arbitrates them against CPU Avalon accesses to the monitor
// RAM / status register, and returns MonDReg and status bits for shift-out.
module uart_module_nios2_gen2_cpu_debug_mem_ctrl
   import uart_module_nios2_gen2_cpu_debug_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int JDO_W  = 38
) (
   input  logic clk,
   input  logic reset_n,
   uart_module_nios2_gen2_cpu_debug_mem_ctrl_if.slave bus
);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] areg_q, areg_d;       // MonAReg
   logic [31:0]       mondreg_q, mondreg_d;
   logic [31:0]       wdata_q, wdata_d;     // JTAG write data held for JWR
   logic [31:0]       readdata_q, readdata_d;
   logic              rdy_q, rdy_d;
   logic              err_q, err_d;
   logic              ovr_q, ovr_d;

   // one-deep slot for strobes that arrive while the FSM is busy
   logic              pend_vld_q, pend_vld_d;
   logic [1:0]        pend_kind_q, pend_kind_d;
   logic [JDO_W-1:0]  pend_jdo_q, pend_jdo_d;

   // command chosen for execution this cycle (pending slot or live strobe)
   logic              exec_vld;
   logic [1:0]        exec_kind;
   logic [JDO_W-1:0]  exec_jdo;

   logic              strobe;
   logic [1:0]        live_kind;
   logic              status_sel;           // address MSB picks status reg

   logic              ram_we;
   logic [3:0]        ram_be;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata, ram_rdata;

   assign strobe     = bus.take_action_ocimem_a | bus.take_action_ocimem_b |
                       bus.take_no_action_ocimem_a;
   assign status_sel = bus.address[ADDR_W];

   // classify the live strobe; ocimem_a outranks ocimem_b outranks no_action
   always_comb begin
      live_kind = CMD_N;
      if (bus.take_action_ocimem_a)      live_kind = CMD_A;
      else if (bus.take_action_ocimem_b) live_kind = CMD_B;
   end

   // next-state logic: strobe capture, IDLE arbitration, FSM sequencing
   always_comb begin
      state_d     = state_q;
      areg_d      = areg_q;
      mondreg_d   = mondreg_q;
      wdata_d     = wdata_q;
      readdata_d  = readdata_q;
      rdy_d       = rdy_q;
      err_d       = err_q;
      ovr_d       = ovr_q;
      pend_vld_d  = pend_vld_q;
      pend_kind_d = pend_kind_q;
      pend_jdo_d  = pend_jdo_q;
      exec_vld    = 1'b0;
      exec_kind   = CMD_A;
      exec_jdo    = '0;
      ram_we      = 1'b0;
      ram_be      = 4'h0;
      ram_addr    = areg_q;
      ram_wdata   = wdata_q;

      // An older pending command always runs first from IDLE; a live strobe
      // goes straight to execution only when IDLE with an empty slot.
      if (state_q == ST_IDLE && pend_vld_q) begin
         exec_vld   = 1'b1;
         exec_kind  = pend_kind_q;
         exec_jdo   = pend_jdo_q;
         pend_vld_d = 1'b0;
      end

      if (strobe) begin
         if (state_q == ST_IDLE && !pend_vld_q) begin
            exec_vld  = 1'b1;
            exec_kind = live_kind;
            exec_jdo  = bus.jdo;
         end else begin
            // overwriting a slot that is not draining this cycle loses a command
            if (pend_vld_q && state_q != ST_IDLE) ovr_d = 1'b1;
            pend_vld_d  = 1'b1;
            pend_kind_d = live_kind;
            pend_jdo_d  = bus.jdo;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (exec_vld) begin
               case (exec_kind)
                  CMD_A: begin
                     areg_d = exec_jdo[ADDR_LSB +: ADDR_W];
                     if (exec_jdo[CLR_STATUS]) begin
                        rdy_d = 1'b0;
                        err_d = 1'b0;
                     end
                     // address-only load finishes here with no busy cycles
                     if (exec_jdo[READ_REQ]) state_d = ST_JRD;
                  end
                  CMD_B: begin
                     wdata_d = exec_jdo[DATA_LSB +: 32];
                     state_d = ST_JWR;
                  end
                  default: state_d = ST_JRD;
               endcase
            end else if (bus.write) begin
               // write wins over a simultaneous read
               if (status_sel) begin
                  if (bus.writedata[SB_READY])   rdy_d = 1'b1;
                  if (bus.writedata[SB_ERROR])   err_d = 1'b1;
                  if (bus.writedata[SB_OVERRUN]) ovr_d = 1'b0;
               end else if (bus.debugaccess) begin
                  ram_we    = 1'b1;
                  ram_be    = bus.byteenable;
                  ram_addr  = bus.address[ADDR_W-1:0];
                  ram_wdata = bus.writedata;
               end
               state_d = ST_AVACK;
            end else if (bus.read) begin
               // issue the RAM read now so the word is ready in AVRD
               ram_addr = bus.address[ADDR_W-1:0];
               state_d  = ST_AVRD;
            end
         end
         ST_JRD: begin
            ram_addr = areg_q;
            state_d  = ST_JCAP;
         end
         ST_JCAP: begin
            mondreg_d = ram_rdata;
            areg_d    = areg_q + 1'b1;
            state_d   = ST_IDLE;
         end
         ST_JWR: begin
            ram_we    = 1'b1;
            ram_be    = 4'hF;
            ram_addr  = areg_q;
            ram_wdata = wdata_q;
            areg_d    = areg_q + 1'b1;
            state_d   = ST_IDLE;
         end
         ST_AVRD: begin
            readdata_d = status_sel ? pack_status(rdy_q, err_q, ovr_q) : ram_rdata;
            state_d    = ST_AVACK;
         end
         ST_AVACK: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // jdo bits outside the address/data/flag fields carry nothing here
   logic unused_jdo_bits;
   assign unused_jdo_bits = ^{exec_jdo[DATA_LSB-1:0], exec_jdo[JDO_W-1:DATA_LSB+32]};

   // state registers, all returned to reset values asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         areg_q      <= '0;
         mondreg_q   <= '0;
         wdata_q     <= '0;
         readdata_q  <= '0;
         rdy_q       <= 1'b0;
         err_q       <= 1'b0;
         ovr_q       <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_kind_q <= CMD_A;
         pend_jdo_q  <= '0;
      end else begin
         state_q     <= state_d;
         areg_q      <= areg_d;
         mondreg_q   <= mondreg_d;
         wdata_q     <= wdata_d;
         readdata_q  <= readdata_d;
         rdy_q       <= rdy_d;
         err_q       <= err_d;
         ovr_q       <= ovr_d;
         pend_vld_q  <= pend_vld_d;
         pend_kind_q <= pend_kind_d;
         pend_jdo_q  <= pend_jdo_d;
      end
   end

   uart_module_nios2_gen2_cpu_debug_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .be_i    (ram_be),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   assign bus.readdata      = readdata_q;
   assign bus.waitrequest   = (state_q != ST_AVACK);
   assign bus.MonDReg       = mondreg_q;
   assign bus.monitor_ready = rdy_q;
   assign bus.monitor_error = err_q;

endmodule
